// File: rtl/xeng_cmac_acc_if.sv
// Stream bus for the complex conjugate MAC: sample input side and dump output side.
interface xeng_cmac_acc_if #(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned N_CHAN = 4
);
  localparam int unsigned CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic                  in_valid;
  logic                  sync;
  logic [2*N_BITS-1:0]   a;
  logic [2*N_BITS-1:0]   b;
  logic [2*ACC_W-1:0]    dout;
  logic [CHAN_W-1:0]     dout_chan;
  logic                  dout_valid;
  logic                  ovf;

  modport master (
    output in_valid, sync, a, b,
    input  dout, dout_chan, dout_valid, ovf
  );

  modport slave (
    input  in_valid, sync, a, b,
    output dout, dout_chan, dout_valid, ovf
  );
endinterface

// File: rtl/xeng_cmac_acc.sv
// Channel-interleaved a*conj(b) accumulator with saturation, sync and per-channel dump.
module xeng_cmac_acc #(
  parameter int unsigned N_BITS  = 4,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned N_CHAN  = 4,
  parameter int unsigned ACC_LEN = 8
) (
  input logic             clk,
  input logic             rst,
  xeng_cmac_acc_if.slave  bus
);
  localparam int unsigned CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned SAMP_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int unsigned PROD_W = 2 * N_BITS + 1;

  // Counters and sample-position decode
  logic [CHAN_W-1:0] r_chan_cnt, w_chan_cur, w_chan_nxt;
  logic [SAMP_W-1:0] r_samp_cnt, w_samp_cur, w_samp_nxt;
  logic              w_chan_wrap;

  always_comb begin
    w_chan_cur  = bus.sync ? '0 : r_chan_cnt;
    w_samp_cur  = bus.sync ? '0 : r_samp_cnt;
    w_chan_wrap = (w_chan_cur == CHAN_W'(N_CHAN - 1));
    w_chan_nxt  = w_chan_wrap ? '0 : w_chan_cur + CHAN_W'(1);
    w_samp_nxt  = w_samp_cur;
    if (w_chan_wrap) begin
      w_samp_nxt = (w_samp_cur == SAMP_W'(ACC_LEN - 1)) ? '0 : w_samp_cur + SAMP_W'(1);
    end
  end

  // S1 registers
  logic                r_s1_valid, r_s1_first, r_s1_last;
  logic [2*N_BITS-1:0] r_s1_a, r_s1_b;
  logic [CHAN_W-1:0]   r_s1_chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan_cnt <= '0;
      r_samp_cnt <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_chan_cnt <= w_chan_nxt;
        r_samp_cnt <= w_samp_nxt;
        r_s1_a     <= bus.a;
        r_s1_b     <= bus.b;
        r_s1_chan  <= w_chan_cur;
        r_s1_first <= (w_samp_cur == '0);
        r_s1_last  <= (w_samp_cur == SAMP_W'(ACC_LEN - 1));
      end
    end
  end

  // S2: full-precision conjugate products
  logic signed [N_BITS-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [PROD_W-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x, w_p_re, w_p_im;

  assign w_ar   = r_s1_a[2*N_BITS-1:N_BITS];
  assign w_ai   = r_s1_a[N_BITS-1:0];
  assign w_br   = r_s1_b[2*N_BITS-1:N_BITS];
  assign w_bi   = r_s1_b[N_BITS-1:0];
  assign w_ar_x = PROD_W'(w_ar);
  assign w_ai_x = PROD_W'(w_ai);
  assign w_br_x = PROD_W'(w_br);
  assign w_bi_x = PROD_W'(w_bi);
  assign w_p_re = w_ar_x * w_br_x + w_ai_x * w_bi_x;
  assign w_p_im = w_ai_x * w_br_x - w_ar_x * w_bi_x;

  logic                     r_s2_valid, r_s2_first, r_s2_last;
  logic signed [PROD_W-1:0] r_s2_re, r_s2_im;
  logic [CHAN_W-1:0]        r_s2_chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_re    <= w_p_re;
        r_s2_im    <= w_p_im;
        r_s2_chan  <= r_s1_chan;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
      end
    end
  end

  // S3: accumulator read-modify-write with per-component saturation
  logic [ACC_W-1:0] r_acc_re [N_CHAN];
  logic [ACC_W-1:0] r_acc_im [N_CHAN];
  logic             r_sat    [N_CHAN];

  logic signed [ACC_W-1:0] w_prod_re, w_prod_im;
  logic [ACC_W-1:0]        w_old_re, w_old_im, w_new_re, w_new_im;
  logic [ACC_W:0]          w_sum_re, w_sum_im;
  logic                    w_clip_re, w_clip_im, w_new_sat;
  logic [ACC_W-1:0]        w_max, w_min;

  always_comb begin
    w_prod_re = ACC_W'(r_s2_re);
    w_prod_im = ACC_W'(r_s2_im);
    w_old_re  = r_acc_re[r_s2_chan];
    w_old_im  = r_acc_im[r_s2_chan];
    w_max     = {1'b0, {(ACC_W-1){1'b1}}};
    w_min     = {1'b1, {(ACC_W-1){1'b0}}};
    // One extra bit is enough: a single product never exceeds the ACC_W range.
    w_sum_re  = {w_old_re[ACC_W-1], w_old_re} + {w_prod_re[ACC_W-1], w_prod_re};
    w_sum_im  = {w_old_im[ACC_W-1], w_old_im} + {w_prod_im[ACC_W-1], w_prod_im};
    w_clip_re = w_sum_re[ACC_W] ^ w_sum_re[ACC_W-1];
    w_clip_im = w_sum_im[ACC_W] ^ w_sum_im[ACC_W-1];
    if (r_s2_first) begin
      w_new_re  = w_prod_re;
      w_new_im  = w_prod_im;
      w_new_sat = 1'b0;
    end else begin
      w_new_re  = w_clip_re ? (w_sum_re[ACC_W] ? w_min : w_max) : w_sum_re[ACC_W-1:0];
      w_new_im  = w_clip_im ? (w_sum_im[ACC_W] ? w_min : w_max) : w_sum_im[ACC_W-1:0];
      w_new_sat = r_sat[r_s2_chan] | w_clip_re | w_clip_im;
    end
  end

  always_ff @(posedge clk) begin
    if (r_s2_valid && !rst) begin
      r_acc_re[r_s2_chan] <= w_new_re;
      r_acc_im[r_s2_chan] <= w_new_im;
      r_sat[r_s2_chan]    <= w_new_sat;
    end
  end

  logic [2*ACC_W-1:0] r_dout;
  logic [CHAN_W-1:0]  r_dout_chan;
  logic               r_dout_valid, r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_chan  <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_dout_valid <= r_s2_valid & r_s2_last;
      if (r_s2_valid && r_s2_last) begin
        r_dout      <= {w_new_re, w_new_im};
        r_dout_chan <= r_s2_chan;
        r_ovf       <= w_new_sat;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_chan  = r_dout_chan;
  assign bus.dout_valid = r_dout_valid;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_xeng_cmac_acc.sv
// Drives three configurations of the MAC from one random stream against a frame-level model.
module tb_xeng_cmac_acc;
  logic       clk = 1'b0;
  logic       rst;
  logic       t_valid, t_sync;
  logic [7:0] t_a, t_b;

  always #5 clk = ~clk;

  xeng_cmac_acc_if #(.N_BITS(4), .ACC_W(20), .N_CHAN(4)) if0 ();
  xeng_cmac_acc_if #(.N_BITS(4), .ACC_W(10), .N_CHAN(1)) if1 ();
  xeng_cmac_acc_if #(.N_BITS(4), .ACC_W(20), .N_CHAN(2)) if2 ();

  assign if0.in_valid = t_valid;
  assign if0.sync     = t_sync;
  assign if0.a        = t_a;
  assign if0.b        = t_b;
  assign if1.in_valid = t_valid;
  assign if1.sync     = t_sync;
  assign if1.a        = t_a;
  assign if1.b        = t_b;
  assign if2.in_valid = t_valid;
  assign if2.sync     = t_sync;
  assign if2.a        = t_a;
  assign if2.b        = t_b;

  xeng_cmac_acc #(.N_BITS(4), .ACC_W(20), .N_CHAN(4), .ACC_LEN(8)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  xeng_cmac_acc #(.N_BITS(4), .ACC_W(10), .N_CHAN(1), .ACC_LEN(8)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  xeng_cmac_acc #(.N_BITS(4), .ACC_W(20), .N_CHAN(2), .ACC_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  int cfg_nch [3] = '{4, 1, 2};
  int cfg_len [3] = '{8, 8, 1};
  int cfg_aw  [3] = '{20, 10, 20};

  // Model state: per-channel sums, sticky clip, frame position
  longint m_re [3][4];
  longint m_im [3][4];
  bit     m_sat[3][4];
  int     m_ch [3];
  int     m_sm [3];

  // Expected dumps, indexed by the edge at which they must appear (mod 4)
  bit     pv  [3][4];
  longint p_re[3][4];
  longint p_im[3][4];
  int     p_ch[3][4];
  bit     p_ov[3][4];

  longint e_re[3];
  longint e_im[3];
  bit     last_ovf[3];
  int     n_strobe[3];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m_ch[c] = 0;
      m_sm[c] = 0;
      e_re[c] = 0;
      e_im[c] = 0;
      for (int s = 0; s < 4; s++) pv[c][s] = 1'b0;
    end
  endfunction

  function automatic void model_sample(input int c, input int ar, input int ai, input int br,
                                       input int bi, input bit s);
    longint re, im, lim;
    int     ch, slot;
    re  = longint'(ar * br + ai * bi);
    im  = longint'(ai * br - ar * bi);
    lim = longint'(1) << (cfg_aw[c] - 1);
    if (s) begin
      m_ch[c] = 0;
      m_sm[c] = 0;
    end
    ch = m_ch[c];
    if (m_sm[c] == 0) begin
      m_re[c][ch]  = re;
      m_im[c][ch]  = im;
      m_sat[c][ch] = 1'b0;
    end else begin
      m_re[c][ch] += re;
      m_im[c][ch] += im;
      if (m_re[c][ch] > lim - 1) begin m_re[c][ch] = lim - 1; m_sat[c][ch] = 1'b1; end
      if (m_re[c][ch] < -lim)    begin m_re[c][ch] = -lim;    m_sat[c][ch] = 1'b1; end
      if (m_im[c][ch] > lim - 1) begin m_im[c][ch] = lim - 1; m_sat[c][ch] = 1'b1; end
      if (m_im[c][ch] < -lim)    begin m_im[c][ch] = -lim;    m_sat[c][ch] = 1'b1; end
    end
    if (m_sm[c] == cfg_len[c] - 1) begin
      slot          = (edge_n + 2) % 4;
      pv[c][slot]   = 1'b1;
      p_re[c][slot] = m_re[c][ch];
      p_im[c][slot] = m_im[c][ch];
      p_ch[c][slot] = ch;
      p_ov[c][slot] = m_sat[c][ch];
    end
    m_ch[c]++;
    if (m_ch[c] == cfg_nch[c]) begin
      m_ch[c] = 0;
      m_sm[c] = (m_sm[c] + 1) % cfg_len[c];
    end
  endfunction

  task automatic check_outputs();
    bit     ov, oovf, xv;
    longint ore, oim, och;
    int     slot;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          ov = if0.dout_valid; oovf = if0.ovf; och = longint'(if0.dout_chan);
          ore = longint'($signed(if0.dout[39:20])); oim = longint'($signed(if0.dout[19:0]));
        end
        1: begin
          ov = if1.dout_valid; oovf = if1.ovf; och = longint'(if1.dout_chan);
          ore = longint'($signed(if1.dout[19:10])); oim = longint'($signed(if1.dout[9:0]));
        end
        default: begin
          ov = if2.dout_valid; oovf = if2.ovf; och = longint'(if2.dout_chan);
          ore = longint'($signed(if2.dout[39:20])); oim = longint'($signed(if2.dout[19:0]));
        end
      endcase
      slot = edge_n % 4;
      xv   = pv[c][slot];
      if (xv) begin
        e_re[c]     = p_re[c][slot];
        e_im[c]     = p_im[c][slot];
        pv[c][slot] = 1'b0;
      end
      if (ov) begin
        last_ovf[c] = oovf;
        n_strobe[c]++;
      end
      chk($sformatf("c%0d_valid", c), longint'(ov), longint'(xv));
      chk($sformatf("c%0d_re", c), ore, e_re[c]);
      chk($sformatf("c%0d_im", c), oim, e_im[c]);
      if (xv) begin
        chk($sformatf("c%0d_chan", c), och, longint'(p_ch[c][slot]));
        chk($sformatf("c%0d_ovf", c), longint'(oovf), longint'(p_ov[c][slot]));
      end
    end
  endtask

  task automatic cyc(input bit v, input bit s, input int ar, input int ai, input int br,
                     input int bi, input bit r);
    t_valid = v;
    t_sync  = s;
    t_a     = {ar[3:0], ai[3:0]};
    t_b     = {br[3:0], bi[3:0]};
    rst     = r;
    @(posedge clk);
    edge_n++;
    if (r) model_reset();
    else if (v) for (int c = 0; c < 3; c++) model_sample(c, ar, ai, br, bi, s);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  function automatic longint c1_re();
    return longint'($signed(if1.dout[19:10]));
  endfunction

  initial begin
    int s0;
    for (int c = 0; c < 3; c++) begin
      n_strobe[c] = 0;
      last_ovf[c] = 1'b0;
    end
    model_reset();
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    idle(2);

    // Ramp into a single channel: 0+1+..+7
    for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, k, 0, 1, 0, 1'b0);
    idle(4);
    chk("t1_re", c1_re(), 28);
    chk("t1_im", longint'($signed(if1.dout[9:0])), 0);

    // Single-sample dumps
    cyc(1'b1, 1'b1, 1, 2, 3, -1, 1'b0);
    idle(3);
    chk("t2a_re", longint'($signed(if2.dout[39:20])), 1);
    chk("t2a_im", longint'($signed(if2.dout[19:0])), 7);
    cyc(1'b1, 1'b0, 0, 1, 0, 1, 1'b0);
    idle(3);
    chk("t2b_re", longint'($signed(if2.dout[39:20])), 1);
    chk("t2b_im", longint'($signed(if2.dout[19:0])), 0);

    // Four interleaved channels
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 4; k++) cyc(1'b1, (r == 0) && (k == 0), k, 0, 1, 0, 1'b0);
    idle(4);
    chk("t3_re", longint'($signed(if0.dout[39:20])), 24);
    chk("t3_chan", longint'(if0.dout_chan), 3);

    // Saturation then a clean frame
    for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, -8, -8, -8, -8, 1'b0);
    idle(4);
    chk("t4_re", c1_re(), 511);
    chk("t4_ovf", longint'(last_ovf[1]), 1);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1, 0, 1, 0, 1'b0);
    idle(4);
    chk("t4b_ovf", longint'(last_ovf[1]), 0);

    // Partial frame discarded by sync
    s0 = n_strobe[1];
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 3, 0, 1, 0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, 1, 0, 1, 0, 1'b0);
    idle(4);
    chk("t5_strobes", longint'(n_strobe[1] - s0), 1);
    chk("t5_re", c1_re(), 8);

    // Gapped valid, then reset mid-frame
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, i == 0, i / 2, 0, 1, 0, 1'b0);
    idle(4);
    chk("t6_re", c1_re(), 28);
    s0 = n_strobe[1];
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, 5, 0, 1, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    idle(4);
    chk("t6_rst_strobes", longint'(n_strobe[1] - s0), 0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, k, 0, 1, 0, 1'b0);
    idle(4);
    chk("t6b_re", c1_re(), 28);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
          int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
          int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
          $urandom_range(0, 299) == 0);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
